// File: rtl/prog_chain_pkg.sv
// prog_chain_pkg: shared types and sizing helpers for the config chain loader.
package prog_chain_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_WORD,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } state_t;

    function automatic int num_words(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    function automatic int bit_cnt_w(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

    localparam int DEF_CHAIN_LEN = 1480;
    localparam int DEF_BIT_CNT_W = bit_cnt_w(DEF_CHAIN_LEN);

endpackage

// File: rtl/prog_chain_loader_timer.sv
// prog_phase_timer: CLK_DIV down-counter, phase_end on the last phase cycle.
module prog_phase_timer
    import prog_chain_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic phase_end
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(CLK_DIV - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign phase_end = (cnt == '0);

endmodule

// File: rtl/prog_chain_loader.sv
// prog_chain_loader: serializes a word stream into the fabric config chain.
// Define PROG_READBACK_EN to capture the old chain contents from prog_out.
module prog_chain_loader
    import prog_chain_pkg::*;
#(
    parameter int CHAIN_LEN = 1480,
    parameter int WORD_W    = 8,
    parameter int CLK_DIV   = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [WORD_W-1:0]              in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic                           prog_in,
    output logic                           prog_clk,
    output logic                           prog_en,
    input  logic                           prog_out,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(CHAIN_LEN+1)-1:0] bit_cnt,
    output logic [WORD_W-1:0]              rd_data,
    output logic                           rd_valid
);

    localparam int CNT_W = bit_cnt_w(CHAIN_LEN);
    localparam int REM_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN);

    state_t            state;
    logic [WORD_W-1:0] sreg;
    logic [WORD_W-1:0] sreg_nx;
    logic [REM_W-1:0]  rem;
    logic              accept;
    logic              phase_end;
    logic              phase_load;

    assign in_ready   = (state == WAIT_WORD);
    assign accept     = in_ready && in_valid;
    assign sreg_nx    = sreg >> 1;
    assign phase_load = accept ||
                        (phase_end && (state == SHIFT_LO || state == SHIFT_HI));

    prog_phase_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (phase_load),
        .phase_end(phase_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sreg     <= '0;
            rem      <= '0;
            bit_cnt  <= '0;
            prog_in  <= 1'b0;
            prog_clk <= 1'b0;
            prog_en  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= WAIT_WORD;
                        busy    <= 1'b1;
                        prog_en <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                WAIT_WORD: begin
                    if (in_valid) begin
                        sreg    <= in_data;
                        prog_in <= in_data[0];
                        rem     <= REM_W'(WORD_W);
                        state   <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (phase_end) begin
                        prog_clk <= 1'b1;
                        bit_cnt  <= bit_cnt + 1'b1;
                        rem      <= rem - 1'b1;
                        state    <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (phase_end) begin
                        prog_clk <= 1'b0;
                        // Chain length wins over leftover word bits.
                        if (bit_cnt == LAST) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            prog_en <= 1'b0;
                            busy    <= 1'b0;
                        end else if (rem != '0) begin
                            sreg    <= sreg_nx;
                            prog_in <= sreg_nx[0];
                            state   <= SHIFT_LO;
                        end else begin
                            state <= WAIT_WORD;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PROG_READBACK_EN
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] PENULT = CNT_W'(CHAIN_LEN - 1);

    logic [WORD_W-1:0] rd_buf;
    logic [WORD_W-1:0] rd_nx;
    logic [IDX_W-1:0]  rd_idx;
    logic              sample;

    assign sample = (state == SHIFT_LO) && phase_end;

    always_comb begin
        rd_nx         = rd_buf;
        rd_nx[rd_idx] = prog_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_buf   <= '0;
            rd_idx   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (state == IDLE && start) begin
                rd_buf <= '0;
                rd_idx <= '0;
            end else if (sample) begin
                if (rd_idx == IDX_W'(WORD_W - 1) || bit_cnt == PENULT) begin
                    rd_data  <= rd_nx;
                    rd_valid <= 1'b1;
                    rd_buf   <= '0;
                    rd_idx   <= '0;
                end else begin
                    rd_buf <= rd_nx;
                    rd_idx <= rd_idx + 1'b1;
                end
            end
        end
    end
`else
    logic unused_prog_out;

    assign unused_prog_out = prog_out;
    assign rd_data         = '0;
    assign rd_valid        = 1'b0;
`endif

endmodule

// File: tb/tb_prog_chain_loader.sv
// tb_prog_chain_loader: scoreboard bench, a 1480/8/1 loader and a 10/4/3 loader.
// Readback checks are compiled in when PROG_READBACK_EN is defined.
module tb_prog_chain_loader;
    import prog_chain_pkg::*;

    localparam int LA  = 1480;
    localparam int NWA = num_words(LA, 8);

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic        start_a, in_valid_a, in_ready_a;
    logic [7:0]  in_data_a, rd_data_a;
    logic        prog_in_a, prog_clk_a, prog_en_a, prog_out_a;
    logic        busy_a, done_a, rd_valid_a;
    logic [10:0] bit_cnt_a;

    logic        start_b, in_valid_b, in_ready_b;
    logic [3:0]  in_data_b, rd_data_b;
    logic        prog_in_b, prog_clk_b, prog_en_b;
    logic        busy_b, done_b, rd_valid_b;
    logic [3:0]  bit_cnt_b;

    prog_chain_loader #(.CHAIN_LEN(LA), .WORD_W(8), .CLK_DIV(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .prog_in(prog_in_a), .prog_clk(prog_clk_a), .prog_en(prog_en_a),
        .prog_out(prog_out_a), .busy(busy_a), .done(done_a),
        .bit_cnt(bit_cnt_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
    );

    prog_chain_loader #(.CHAIN_LEN(10), .WORD_W(4), .CLK_DIV(3)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .prog_in(prog_in_b), .prog_clk(prog_clk_b), .prog_en(prog_en_b),
        .prog_out(1'b0), .busy(busy_b), .done(done_b),
        .bit_cnt(bit_cnt_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
    );

    // Behavioural fabric chain behind dut_a.
    logic [LA-1:0] chain = '0;
    always @(posedge prog_clk_a) chain <= {chain[LA-2:0], prog_in_a};
    assign prog_out_a = chain[LA-1];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    bit         qa[$];
    bit         qb[$];
    logic [7:0] rq[$];
    bit         rb_on = 1'b0;
    int         edges_a = 0, done_cnt_a = 0, done_cyc_a = -1, rd_cnt_a = 0;
    int         edges_b = 0, done_cnt_b = 0, hi_b = 0, acc_b = 0;
    logic       pclk_a_q = 1'b0, pin_a_q = 1'b0;
    logic       pclk_b_q = 1'b0, pin_b_q = 1'b0;

    always @(negedge clk) begin
        if (prog_clk_a && !pclk_a_q) begin
            edges_a++;
            if (qa.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL a_edge: extra edge at bit_cnt %0d", bit_cnt_a);
            end else begin
                check("a_bit", prog_in_a, qa.pop_front());
            end
        end
        if (prog_clk_a && pclk_a_q) check("a_hold", prog_in_a, pin_a_q);
        if (done_a) begin
            done_cnt_a++;
            done_cyc_a = cyc;
        end
        if (rd_valid_a) begin
            rd_cnt_a++;
            if (rb_on) begin
                if (rq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL a_rd: extra word %0h", rd_data_a);
                end else begin
                    check("a_rd", rd_data_a, rq.pop_front());
                end
            end
        end
        pclk_a_q = prog_clk_a;
        pin_a_q  = prog_in_a;
    end

    always @(negedge clk) begin
        if (prog_clk_b && !pclk_b_q) begin
            edges_b++;
            if (qb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL b_edge: extra edge at bit_cnt %0d", bit_cnt_b);
            end else begin
                check("b_bit", prog_in_b, qb.pop_front());
            end
        end
        if (prog_clk_b && pclk_b_q) check("b_hold", prog_in_b, pin_b_q);
        if (prog_clk_b) begin
            hi_b++;
        end else begin
            if (hi_b != 0) check("b_hi_len", hi_b, 3);
            hi_b = 0;
        end
        if (done_b) done_cnt_b++;
        pclk_b_q = prog_clk_b;
        pin_b_q  = prog_in_b;
    end

    always @(posedge clk) if (in_valid_b && in_ready_b) acc_b++;

    task automatic send_a(input logic [7:0] w, input int nb);
        int k;
        in_data_a  = w;
        in_valid_a = 1'b1;
        k = 0;
        while (!in_ready_a && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("a_accept", in_ready_a, 1'b1);
        if (in_ready_a) for (int b = 0; b < nb; b++) qa.push_back(w[b]);
        @(posedge clk);
        #1;
    endtask

    task automatic send_b(input logic [3:0] w, input int nb);
        int k;
        in_data_b  = w;
        in_valid_b = 1'b1;
        k = 0;
        while (!in_ready_b && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("b_accept", in_ready_b, 1'b1);
        if (in_ready_b) for (int b = 0; b < nb; b++) qb.push_back(w[b]);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_a(output int t0);
        @(negedge clk);
        #1;
        start_a = 1'b1;
        t0      = cyc;
        @(negedge clk);
        #1;
        start_a = 1'b0;
    endtask

    task automatic reset_checks_a(input string tag);
        check({tag, "_prog_in"}, prog_in_a, 1'b0);
        check({tag, "_prog_clk"}, prog_clk_a, 1'b0);
        check({tag, "_prog_en"}, prog_en_a, 1'b0);
        check({tag, "_busy"}, busy_a, 1'b0);
        check({tag, "_done"}, done_a, 1'b0);
        check({tag, "_bit_cnt"}, bit_cnt_a, 0);
        check({tag, "_in_ready"}, in_ready_a, 1'b0);
        check({tag, "_rd_valid"}, rd_valid_a, 1'b0);
        check({tag, "_rd_data"}, rd_data_a, 0);
    endtask

    task automatic full_load_a(input string tag, input logic [LA-1:0] bs,
                               input bit poke);
        int e0, d0, t0, k;
        e0 = edges_a;
        d0 = done_cnt_a;
        pulse_start_a(t0);
        for (int i = 0; i < NWA; i++) begin
            send_a(bs[8*i +: 8], 8);
            if (poke && i == 10) begin
                start_a = 1'b1;
                @(posedge clk);
                #1;
                start_a = 1'b0;
                check({tag, "_busy_mid"}, busy_a, 1'b1);
            end
        end
        in_valid_a = 1'b0;
        k = 0;
        while (done_cnt_a == d0 && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        check({tag, "_done_cyc"}, done_cyc_a - t0, 3146);
        @(negedge clk);
        #1;
        check({tag, "_edges"}, edges_a - e0, LA);
        check({tag, "_q_empty"}, qa.size(), 0);
        check({tag, "_done_cnt"}, done_cnt_a - d0, 1);
        check({tag, "_done_low"}, done_a, 1'b0);
        check({tag, "_prog_en"}, prog_en_a, 1'b0);
        check({tag, "_busy"}, busy_a, 1'b0);
        check({tag, "_bit_cnt"}, bit_cnt_a, LA);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LA-1:0] bs1, bs2;
        int k, err, t0, rd0, d0;

        reset      = 1'b1;
        start_a    = 1'b0;
        in_valid_a = 1'b0;
        in_data_a  = '0;
        start_b    = 1'b0;
        in_valid_b = 1'b0;
        in_data_b  = '0;
        for (int i = 0; i < LA; i++) begin
            bs1[i] = 1'($urandom_range(0, 1));
            bs2[i] = 1'($urandom_range(0, 1));
        end

        repeat (3) @(posedge clk);
        #1;
        reset_checks_a("rst");
        check("rst_b_bit_cnt", bit_cnt_b, 0);
        check("rst_b_prog_en", prog_en_b, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        full_load_a("load1", bs1, 1'b1);

`ifdef PROG_READBACK_EN
        for (int i = 0; i < NWA; i++) rq.push_back(bs1[8*i +: 8]);
        rb_on = 1'b1;
`endif
        rd0 = rd_cnt_a;
        full_load_a("load2", bs2, 1'b0);
`ifdef PROG_READBACK_EN
        repeat (2) @(negedge clk);
        #1;
        check("rb_count", rd_cnt_a - rd0, NWA);
        check("rb_q_empty", rq.size(), 0);
        rb_on = 1'b0;
`endif

        pulse_start_a(t0);
        for (int i = 0; i < 88; i++) send_a(bs1[8*i +: 8], 8);
        in_valid_a = 1'b0;
        k = 0;
        while (bit_cnt_a != 700 && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("mid_bit_cnt", bit_cnt_a, 700);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset_checks_a("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        qa.delete();

        full_load_a("reload", bs2, 1'b0);

        pulse_start_b();
        send_b(4'hA, 4);
        send_b(4'h5, 4);
        in_valid_b = 1'b0;
        k = 0;
        while (!in_ready_b && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        err = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (prog_clk_b || !prog_en_b || !in_ready_b) err++;
        end
        check("b_stall", err, 0);
        send_b(4'hF, 2);
        in_valid_b = 1'b0;
        d0 = 0;
        k = 0;
        while (done_cnt_b == d0 && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        @(negedge clk);
        #1;
        check("b_done_cnt", done_cnt_b, 1);
        check("b_edges", edges_b, 10);
        check("b_q_empty", qb.size(), 0);
        check("b_accepts", acc_b, 3);
        check("b_bit_cnt", bit_cnt_b, 10);
        check("b_prog_en", prog_en_b, 1'b0);
        check("b_busy", busy_b, 1'b0);

`ifndef PROG_READBACK_EN
        check("rd_never", rd_cnt_a, 0);
        check("rd_data_zero", rd_data_a, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    task automatic pulse_start_b();
        @(negedge clk);
        #1;
        start_b = 1'b1;
        @(negedge clk);
        #1;
        start_b = 1'b0;
    endtask

endmodule
